div_seq: RTL and testbench

//  Multi-cycle radix-2 restoring divider sequencer for DIV/DIVU in the EX stage.
//  - Latches operands on start, runs one quotient bit per cycle, fixes signs, returns {HI,LO}.
//  - Holds stall_o to the pipeline stall controller so EX and earlier stages freeze until the result is ready.
//  - Sits beside the EX ALU and is driven by the EX aluop decode.

---
 rtl/div_seq_if.sv | 26 ++
 rtl/div_seq.sv | 136 +++++++++++++
 tb/tb_div_seq.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/div_seq_if.sv
// Handshake bundle between the EX-stage decode and the sequential divider.
// Carries the request, operands, result and pipeline stall request.
interface div_seq_if #(
  parameter int WIDTH = 32
);
  logic               start_i;
  logic               annul_i;
  logic               signed_div_i;
  logic [WIDTH-1:0]   opdata1_i;
  logic [WIDTH-1:0]   opdata2_i;
  logic [2*WIDTH-1:0] result_o;
  logic               ready_o;
  logic               stall_o;

  modport master (
    output start_i, annul_i, signed_div_i,
    output opdata1_i, opdata2_i,
    input  result_o, ready_o, stall_o
  );

  modport slave (
    input  start_i, annul_i, signed_div_i,
    input  opdata1_i, opdata2_i,
    output result_o, ready_o, stall_o
  );
endinterface

// File: rtl/div_seq.sv
// Radix-2 restoring divider for DIV/DIVU, one quotient bit per cycle.
// Optional DIV_EARLY_ZERO_EN: zero dividend short-cuts to a zero result.
module div_seq #(
  parameter int WIDTH = 32
) (
  input  logic      clk,
  input  logic      rst,
  div_seq_if.slave  bus
);
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    FREE, BYZERO, ON, END
  } state_t;

  state_t             state;
  state_t             state_n;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   dvd;
  logic [WIDTH-1:0]   dvs;
  logic [WIDTH-1:0]   rem;
  logic               sgn;
  logic               s1;
  logic               s2;
  logic [2*WIDTH-1:0] result;
  logic               ready;
  logic               stall;

  logic               accept;
  logic               zero_req;
  logic               last;
  logic [WIDTH-1:0]   abs1;
  logic [WIDTH-1:0]   abs2;
  logic [WIDTH:0]     shifted;
  logic [WIDTH:0]     diff;
  logic               ge;
  logic [WIDTH-1:0]   rem_step;
  logic [WIDTH-1:0]   quot_fix;
  logic [WIDTH-1:0]   rem_fix;

  assign accept = (state == FREE) & bus.start_i & ~bus.annul_i;
  assign last   = (cnt == CW'(WIDTH));

`ifdef DIV_EARLY_ZERO_EN
  assign zero_req = (bus.opdata2_i == '0) | (bus.opdata1_i == '0);
`else
  assign zero_req = (bus.opdata2_i == '0);
`endif

  assign abs1 = (bus.signed_div_i & bus.opdata1_i[WIDTH-1])
              ? ('0 - bus.opdata1_i) : bus.opdata1_i;
  assign abs2 = (bus.signed_div_i & bus.opdata2_i[WIDTH-1])
              ? ('0 - bus.opdata2_i) : bus.opdata2_i;

  assign shifted  = {rem, dvd[WIDTH-1]};
  assign ge       = (shifted >= {1'b0, dvs});
  assign diff     = shifted - {1'b0, dvs};
  assign rem_step = ge ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];

  assign quot_fix = (sgn & (s1 ^ s2)) ? ('0 - dvd) : dvd;
  assign rem_fix  = (sgn & s1) ? ('0 - rem) : rem;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= FREE;
    else     state <= state_n;
  end

  // Next-state and stall request
  always_comb begin
    state_n = state;
    stall   = 1'b0;
    unique case (state)
      FREE: begin
        if (accept) begin
          stall   = 1'b1;
          state_n = zero_req ? BYZERO : ON;
        end
      end
      BYZERO: begin
        stall   = 1'b1;
        state_n = bus.annul_i ? FREE : END;
      end
      ON: begin
        stall = 1'b1;
        if (bus.annul_i) state_n = FREE;
        else if (last)   state_n = END;
      end
      END: begin
        if (bus.annul_i | ~bus.start_i)
          state_n = FREE;
      end
      default: state_n = FREE;
    endcase
  end

  // Operand latch, iteration step and result register
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      dvd    <= '0;
      dvs    <= '0;
      rem    <= '0;
      sgn    <= 1'b0;
      s1     <= 1'b0;
      s2     <= 1'b0;
      result <= '0;
      ready  <= 1'b0;
    end else begin
      ready <= (state_n == END);
      if (state == END && state_n == END)
        result <= result;
      else if (state == ON && state_n == END)
        result <= {rem_fix, quot_fix};
      else
        result <= '0;
      if (accept) begin
        cnt <= '0;
        dvd <= abs1;
        dvs <= abs2;
        rem <= '0;
        sgn <= bus.signed_div_i;
        s1  <= bus.signed_div_i & bus.opdata1_i[WIDTH-1];
        s2  <= bus.signed_div_i & bus.opdata2_i[WIDTH-1];
      end else if (state == ON && !last) begin
        rem <= rem_step;
        dvd <= {dvd[WIDTH-2:0], ge};
        cnt <= cnt + CW'(1);
      end
    end
  end

  assign bus.result_o = result;
  assign bus.ready_o  = ready;
  assign bus.stall_o  = stall;
endmodule

// File: tb/tb_div_seq.sv
// Randomised and directed bench for div_seq.
// Expected results come from 64-bit integer division in the bench.
module tb_div_seq;
  logic clk = 1'b0;
  logic rst;
  int   errs   = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  div_seq_if #(.WIDTH(32)) bus ();

  div_seq #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic sgn,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
    longint x, y, q, r;
    if (b == 32'd0) return 64'd0;
    if (sgn) begin
      x = longint'($signed(a));
      y = longint'($signed(b));
    end else begin
      x = longint'({32'd0, a});
      y = longint'({32'd0, b});
    end
    q = x / y;
    r = x % y;
    return {r[31:0], q[31:0]};
  endfunction

  function automatic int lat(input logic [31:0] a,
                             input logic [31:0] b);
    if (b == 32'd0) return 2;
`ifdef DIV_EARLY_ZERO_EN
    if (a == 32'd0) return 2;
`endif
    return 34;
  endfunction

  task automatic run_div(input string tag,
                         input logic sgn,
                         input logic [31:0] a,
                         input logic [31:0] b,
                         input bit scramble);
    int n;
    int bad;
    bit done;
    logic [63:0] exp;
    exp = model(sgn, a, b);
    @(negedge clk);
    bus.start_i      = 1'b1;
    bus.annul_i      = 1'b0;
    bus.signed_div_i = sgn;
    bus.opdata1_i    = a;
    bus.opdata2_i    = b;
    #1 check({tag, "_stall_req"}, 64'(bus.stall_o), 64'd1);
    n = 0;
    bad = 0;
    done = 0;
    while (!done && n < 100) begin
      @(posedge clk);
      n++;
      if (scramble) begin
        #1;
        bus.opdata1_i    = $urandom;
        bus.opdata2_i    = $urandom;
        bus.signed_div_i = 1'($urandom);
      end
      @(negedge clk);
      if (bus.ready_o) done = 1;
      else if (!bus.stall_o) bad++;
    end
    check({tag, "_latency"}, 64'(n), 64'(lat(a, b)));
    check({tag, "_stall_busy"}, 64'(bad), 64'd0);
    check({tag, "_stall_end"}, 64'(bus.stall_o), 64'd0);
    check({tag, "_result"}, bus.result_o, exp);
    @(negedge clk);
    check({tag, "_hold_rdy"}, 64'(bus.ready_o), 64'd1);
    check({tag, "_hold_res"}, bus.result_o, exp);
    bus.start_i = 1'b0;
    @(negedge clk);
    check({tag, "_drop_rdy"}, 64'(bus.ready_o), 64'd0);
    check({tag, "_drop_res"}, bus.result_o, 64'd0);
  endtask

  initial begin
    int hits;
    logic [31:0] a, b;
    rst              = 1'b1;
    bus.start_i      = 1'b0;
    bus.annul_i      = 1'b0;
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = '0;
    bus.opdata2_i    = '0;
    repeat (3) @(negedge clk);
    check("rst_ready", 64'(bus.ready_o), 64'd0);
    check("rst_result", bus.result_o, 64'd0);
    check("rst_stall", 64'(bus.stall_o), 64'd0);
    rst = 1'b0;

    run_div("divu_7_2", 1'b0, 32'd7, 32'd2, 0);
    run_div("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 0);
    run_div("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_div("divu_big", 1'b0, 32'hFFFF_FFFF, 32'h10, 0);
    run_div("divu_by0", 1'b0, 32'd5, 32'd0, 0);
    run_div("div_by0", 1'b1, 32'h8000_0000, 32'd0, 1);
    run_div("divu_zero", 1'b0, 32'd0, 32'd3, 0);
    run_div("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 1);

    // annul mid-divide
    @(negedge clk);
    bus.start_i      = 1'b1;
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = 32'd100;
    bus.opdata2_i    = 32'd7;
    repeat (10) @(negedge clk);
    bus.annul_i = 1'b1;
    bus.start_i = 1'b0;
    @(negedge clk);
    bus.annul_i = 1'b0;
    check("annul_stall", 64'(bus.stall_o), 64'd0);
    check("annul_ready", 64'(bus.ready_o), 64'd0);
    hits = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.ready_o) hits++;
    end
    check("annul_no_rdy", 64'(hits), 64'd0);

    // reset mid-divide
    bus.start_i   = 1'b1;
    bus.opdata1_i = 32'd12345;
    bus.opdata2_i = 32'd11;
    repeat (20) @(negedge clk);
    rst         = 1'b1;
    bus.start_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check("mrst_ready", 64'(bus.ready_o), 64'd0);
    check("mrst_result", bus.result_o, 64'd0);
    check("mrst_stall", 64'(bus.stall_o), 64'd0);
    hits = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.ready_o) hits++;
    end
    check("mrst_no_rdy", 64'(hits), 64'd0);

    for (int i = 0; i < 16; i++) begin
      a = $urandom;
      case ($urandom_range(0, 3))
        0:       b = 32'd0;
        1:       b = $urandom_range(1, 15);
        2:       b = ~32'($urandom_range(0, 15));
        default: b = $urandom;
      endcase
      if (i == 5) a = 32'd0;
      run_div($sformatf("rnd%0d", i), 1'($urandom), a, b, 1'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
